// File: rtl/hdmi_pkt_pkg.sv
// Shared packet geometry, packet layout and the BCH ECC step for the HDMI data-island assembler.
package hdmi_pkt_pkg;
    localparam int HDR_W      = 24;
    localparam int SUB_W      = 56;
    localparam int NSUB       = 4;
    localparam int PKT_PIXELS = 32;
    localparam int ECC_BITS   = 8;
    localparam int PKT_W      = HDR_W + NSUB * SUB_W;

    localparam logic [HDR_W-1:0] NULL_HEADER = 24'h000000;

    // Header in the low bits, subpacket 0 directly above it.
    typedef struct packed {
        logic [NSUB-1:0][SUB_W-1:0] sub;
        logic [HDR_W-1:0]           header;
    } packet_t;

    function automatic logic [ECC_BITS-1:0] ecc_step(
        input logic [ECC_BITS-1:0] e,
        input logic                b,
        input logic [ECC_BITS-1:0] poly
    );
        return (e >> 1) ^ ((e[0] ^ b) ? poly : '0);
    endfunction
endpackage

// File: rtl/packet_fifo.sv
// First-word-fall-through packet FIFO; rd_data shows the head whenever empty is low.
module packet_fifo #(
    parameter int WIDTH = 248,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_pixel) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/packet_assembler_fifo.sv
// HDMI data-island packet assembler: buffers whole packets, then serialises header and
// subpackets 9 bits per pixel with BCH parity appended, substituting null packets on underrun.
module packet_assembler_fifo
    import hdmi_pkt_pkg::*;
#(
    parameter int                  FIFO_DEPTH = 2,
    parameter int                  IDX_W      = 5,
    parameter logic [ECC_BITS-1:0] ECC_POLY   = 8'h83
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   data_island_period,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic [HDR_W-1:0]       pkt_header,
    input  logic [NSUB*SUB_W-1:0]  pkt_sub,
    output logic [8:0]             packet_data,
    output logic [4:0]             counter,
    output logic [IDX_W-1:0]       packet_index,
    output logic                   packet_start,
    output logic                   underrun
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // pkt_valid/pkt_ready: a packet transfers on every clk_pixel edge where both are high.
    // pkt_ready comes only from the registered FIFO count, never from pkt_valid, so the
    // producer holds pkt_valid and its payload stable until it sees the transfer.
    logic [PKT_W-1:0]        fifo_rd_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_push;
    logic                    fifo_pop;

    packet_t                 head;
    packet_t                 active;
    logic                    active_valid;
    logic [NSUB*ECC_BITS+ECC_BITS-1:0] parity;
    logic [NSUB*ECC_BITS+ECC_BITS-1:0] parity_next;

    logic                    last_pixel;
    logic                    load_idle;
    logic                    load_boundary;
    logic                    abort_packet;
    logic [5:0]              c2;
    logic [5:0]              c2p;
    logic [SUB_W+ECC_BITS-1:0] sub_bch;
    logic [HDR_W+ECC_BITS-1:0] hdr_bch;

    assign pkt_ready     = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign fifo_push     = pkt_valid && !fifo_full;
    assign head          = packet_t'(fifo_rd_data);
    assign last_pixel    = (counter == 5'd31);
    assign load_idle     = !data_island_period && !active_valid && !fifo_empty;
    assign load_boundary = data_island_period && last_pixel;
    assign fifo_pop      = (load_idle || load_boundary) && !fifo_empty;
    // A non-zero counter with the island gone low means the active packet was cut short.
    assign abort_packet  = !data_island_period && (counter != 5'd0);
    assign c2            = {counter, 1'b0};
    assign c2p           = {counter, 1'b1};

    packet_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .wr_data   ({pkt_sub, pkt_header}),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Two subpacket bits and one header bit enter the ECC per pixel; parity then holds while sent.
    always_comb begin
        parity_next = parity;
        if (!data_island_period || last_pixel) begin
            parity_next = '0;
        end else begin
            if (counter < 5'd28) begin
                for (int k = 0; k < NSUB; k++) begin
                    parity_next[ECC_BITS*k +: ECC_BITS] = ecc_step(
                        ecc_step(parity[ECC_BITS*k +: ECC_BITS], active.sub[k][c2], ECC_POLY),
                        active.sub[k][c2p], ECC_POLY);
                end
            end
            if (counter < 5'd24) begin
                parity_next[ECC_BITS*NSUB +: ECC_BITS] = ecc_step(
                    parity[ECC_BITS*NSUB +: ECC_BITS], active.header[counter], ECC_POLY);
            end
        end
    end

    always_comb begin
        packet_data = '0;
        sub_bch     = '0;
        hdr_bch     = {parity[ECC_BITS*NSUB +: ECC_BITS], active.header};
        packet_data[0] = hdr_bch[counter];
        for (int k = 0; k < NSUB; k++) begin
            sub_bch = {parity[ECC_BITS*k +: ECC_BITS], active.sub[k]};
            packet_data[1+k] = sub_bch[c2];
            packet_data[5+k] = sub_bch[c2p];
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter      <= '0;
            packet_index <= '0;
            packet_start <= 1'b0;
            underrun     <= 1'b0;
            active       <= '0;
            active_valid <= 1'b0;
            parity       <= '0;
        end else begin
            counter      <= data_island_period ? counter + 5'd1 : 5'd0;
            packet_start <= data_island_period && (counter == 5'd0);
            underrun     <= data_island_period && (counter == 5'd0) && !active_valid;
            parity       <= parity_next;
            if (!data_island_period) begin
                packet_index <= '0;
            end else if (last_pixel) begin
                packet_index <= packet_index + IDX_W'(1);
            end
            if (fifo_pop) begin
                active       <= head;
                active_valid <= 1'b1;
            end else if (load_boundary || abort_packet) begin
                active       <= '0;
                active_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_packet_assembler_fifo.sv
// Scoreboard bench for packet_assembler_fifo: island drivers queue expected pixels from a
// bit-serial ECC model, a negedge monitor pops and compares every island pixel.
module tb_packet_assembler_fifo;
    localparam logic [7:0] POLY = 8'h83;

    typedef struct {
        logic [23:0]  hdr;
        logic [223:0] sub;
    } pkt_s;

    logic         clk_pixel = 1'b0;
    logic         reset = 1'b1;
    logic         dip = 1'b0;
    logic         pkt_valid = 1'b0;
    logic [23:0]  pkt_header = '0;
    logic [223:0] pkt_sub = '0;
    logic         pkt_ready;
    logic [8:0]   packet_data;
    logic [4:0]   counter;
    logic [4:0]   packet_index;
    logic         packet_start;
    logic         underrun;

    pkt_s         pending[$];
    logic [20:0]  exp_q[$];
    logic [20:0]  mon_act;
    logic [20:0]  mon_exp;
    logic [31:0]  cap_bit0;
    int           checks = 0;
    int           errors = 0;
    int           bp_wait;

    packet_assembler_fifo #(
        .FIFO_DEPTH (2),
        .IDX_W      (5),
        .ECC_POLY   (POLY)
    ) dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (dip),
        .pkt_valid          (pkt_valid),
        .pkt_ready          (pkt_ready),
        .pkt_header         (pkt_header),
        .pkt_sub            (pkt_sub),
        .packet_data        (packet_data),
        .counter            (counter),
        .packet_index       (packet_index),
        .packet_start       (packet_start),
        .underrun           (underrun)
    );

    // Clock and watchdog
    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial reference ECC over each subpacket (56 bits) and the header (24 bits).
    function automatic logic [39:0] ref_parity(input pkt_s p);
        logic [39:0] par;
        logic [7:0]  e;
        logic        fb;
        par = '0;
        for (int k = 0; k < 4; k++) begin
            e = '0;
            for (int i = 0; i < 56; i++) begin
                fb = e[0] ^ p.sub[56*k+i];
                e  = e >> 1;
                if (fb) e = e ^ POLY;
            end
            par[8*k +: 8] = e;
        end
        e = '0;
        for (int i = 0; i < 24; i++) begin
            fb = e[0] ^ p.hdr[i];
            e  = e >> 1;
            if (fb) e = e ^ POLY;
        end
        par[32 +: 8] = e;
        return par;
    endfunction

    function automatic logic [8:0] ref_pixel(input pkt_s p, input logic [39:0] par, input int c);
        logic [63:0] b;
        logic [31:0] h;
        logic [8:0]  d;
        h    = {par[39:32], p.hdr};
        d    = '0;
        d[0] = h[c];
        for (int k = 0; k < 4; k++) begin
            b      = {par[8*k +: 8], p.sub[56*k +: 56]};
            d[1+k] = b[2*c];
            d[5+k] = b[2*c+1];
        end
        return d;
    endfunction

    task automatic push_pkt(input logic [23:0] h, input logic [223:0] s, input bit model);
        int   waited;
        pkt_s p;
        waited = 0;
        @(posedge clk_pixel); #1;
        pkt_valid  = 1'b1;
        pkt_header = h;
        pkt_sub    = s;
        @(negedge clk_pixel);
        while (!pkt_ready && waited < 100) begin
            waited++;
            @(negedge clk_pixel);
        end
        if (!pkt_ready) check("push_accept_timeout", 32'(pkt_ready), 32'd1);
        @(posedge clk_pixel); #1;
        pkt_valid = 1'b0;
        if (model) begin
            p.hdr = h;
            p.sub = s;
            pending.push_back(p);
        end
    endtask

    // Queue expectations for n packet slots (or the first cut pixels), then drive the island.
    task automatic run_island(input int n, input int cut, input bit do_reset);
        int          total;
        pkt_s        p;
        bit          is_null;
        logic [39:0] par;
        total = (cut > 0) ? cut : n * 32;
        for (int s = 0; s < n; s++) begin
            if (pending.size() > 0) begin
                p       = pending.pop_front();
                is_null = 1'b0;
            end else begin
                p.hdr   = '0;
                p.sub   = '0;
                is_null = 1'b1;
            end
            par = ref_parity(p);
            for (int c = 0; c < 32; c++) begin
                if (s * 32 + c < total) begin
                    exp_q.push_back({5'(s), 5'(c), 1'(c == 1), 1'((c == 1) && is_null),
                                     ref_pixel(p, par, c)});
                end
            end
        end
        repeat (2) @(posedge clk_pixel);
        #1 dip = 1'b1;
        repeat (total - 1) @(posedge clk_pixel);
        #1;
        if (do_reset) reset = 1'b1;
        @(posedge clk_pixel); #1;
        dip   = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_counter"},      32'(counter),      32'd0);
        check({tag, "_packet_index"}, 32'(packet_index), 32'd0);
        check({tag, "_packet_start"}, 32'(packet_start), 32'd0);
        check({tag, "_underrun"},     32'(underrun),     32'd0);
        check({tag, "_pkt_ready"},    32'(pkt_ready),    32'd1);
        check({tag, "_packet_data"},  32'(packet_data),  32'd0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk_pixel) begin
        if (dip) begin
            mon_act = {packet_index, counter, packet_start, underrun, packet_data};
            cap_bit0[counter] = packet_data[0];
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL island_pixel: unexpected pixel %0h with no expectation queued", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                check("island_pixel", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    initial begin
        logic [223:0] rsub;
        int           done;
        int           n;

        // Reset
        repeat (3) @(posedge clk_pixel);
        #1 reset = 1'b0;
        @(negedge clk_pixel);
        check_reset_values("after_reset");

        // One packet with header 1: bit0 stream is header then its parity byte (0x4A).
        push_pkt(24'h000001, '0, 1'b1);
        cap_bit0 = '0;
        run_island(1, 0, 1'b0);
        check("hdr1_bit0_stream", cap_bit0, 32'h4A00_0001);

        // Three slots, two packets: third slot is a null packet with underrun.
        push_pkt(24'h0000B1, {7{32'h1234_5678}}, 1'b1);
        push_pkt(24'h0000B2, {7{32'h9ABC_DEF0}}, 1'b1);
        run_island(3, 0, 1'b0);

        // Full FIFO: the blocked push lands on the first pixel after the boundary pop.
        push_pkt(24'h0000A1, {7{32'h0F0F_0F0F}}, 1'b1);
        push_pkt(24'h0000A2, {7{32'hAAAA_5555}}, 1'b1);
        push_pkt(24'h0000A3, {7{32'h0000_FFFF}}, 1'b1);
        @(negedge clk_pixel);
        check("full_pkt_ready", 32'(pkt_ready), 32'd0);
        pending.push_back('{hdr: 24'h0000A4, sub: {7{32'hC3C3_3C3C}}});
        fork
            run_island(4, 0, 1'b0);
            begin
                bp_wait = 0;
                @(posedge clk_pixel); #1;
                pkt_valid  = 1'b1;
                pkt_header = 24'h0000A4;
                pkt_sub    = {7{32'hC3C3_3C3C}};
                @(negedge clk_pixel);
                while (!pkt_ready && bp_wait < 200) begin
                    bp_wait++;
                    @(negedge clk_pixel);
                end
                check("blocked_push_ready", 32'(pkt_ready), 32'd1);
                check("blocked_push_counter", 32'(counter), 32'd0);
                check("blocked_push_index", 32'(packet_index), 32'd1);
                @(posedge clk_pixel); #1;
                pkt_valid = 1'b0;
            end
        join

        // Random packets, up to three per island.
        done = 0;
        while (done < 1000) begin
            n = (1000 - done < 3) ? (1000 - done) : 3;
            for (int i = 0; i < n; i++) begin
                for (int w = 0; w < 7; w++) rsub[32*w +: 32] = $urandom();
                push_pkt(24'($urandom_range(24'hFFFFFF, 0)), rsub, 1'b1);
            end
            run_island(n, 0, 1'b0);
            done += n;
        end

        // Island dropped at counter 10: partial packet discarded, next one loaded cleanly.
        push_pkt(24'h0000C1, {7{32'hDEAD_BEEF}}, 1'b1);
        push_pkt(24'h0000C2, {7{32'hCAFE_F00D}}, 1'b1);
        run_island(1, 10, 1'b0);
        @(negedge clk_pixel);
        check("drop_cycle_counter", 32'(counter), 32'd10);
        @(negedge clk_pixel);
        check("after_drop_counter", 32'(counter), 32'd0);
        check("after_drop_index", 32'(packet_index), 32'd0);
        run_island(1, 0, 1'b0);

        // Reset at counter 17 with two packets queued behind the active one.
        push_pkt(24'h0000D1, {7{32'h1111_2222}}, 1'b1);
        push_pkt(24'h0000D2, {7{32'h3333_4444}}, 1'b1);
        push_pkt(24'h0000D3, {7{32'h5555_6666}}, 1'b1);
        run_island(1, 18, 1'b1);
        @(negedge clk_pixel);
        check_reset_values("mid_island_reset");
        pending.delete();
        run_island(1, 0, 1'b0);

        repeat (2) @(posedge clk_pixel);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
